// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller that time-shares one full adder
// A WIDTH-bit addition takes WIDTH RUN cycles, then a one-cycle DONE pulse.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] r_shift;

  full_adder u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_sum),
    .co (fa_cout)
  );

  // Result bits enter at the MSB so the LSB computed first ends up at bit 0.
  generate
    if (WIDTH == 1) begin : g_r1
      assign r_shift = fa_sum;
    end else begin : g_rn
      assign r_shift = {fa_sum, r_sh_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        r_sh_d  = r_shift;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = fa_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = r_shift;
          cout_d  = fa_cout;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl
// Transaction-level model predicts busy/done/sum/cout from accept times and a+b+cin.

module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int vectors = 0;
  int errors  = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an op accepted at edge n0 is busy after edges n0..n0+W-1 and done after edge n0+W.
  int         cyc      = 0;
  int         n0       = 0;
  bit         act_v    = 0;
  bit         in_run   = 0;
  int         accepted = 0;
  logic [W:0] pend     = '0;
  logic [W:0] res      = '0;
  bit         exp_busy = 0;
  bit         exp_done = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; act_v = 0; n0 = 0; res = '0; exp_busy = 0; exp_done = 0;
    end else begin
      cyc++;
      in_run = act_v && (cyc >= n0 + 1) && (cyc <= n0 + W);
      if (!in_run && start) begin
        act_v = 1;
        n0    = cyc;
        pend  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        accepted++;
      end
      exp_busy = act_v && (cyc >= n0) && (cyc <= n0 + W - 1);
      exp_done = act_v && (cyc == n0 + W);
      if (exp_done) res = pend;
    end
  end

  always @(negedge clk) begin
    check("busy", busy, exp_busy);
    check("done", done, exp_done);
    check("sum", sum, res[W-1:0]);
    check("cout", cout, res[W]);
    if (done && busy) check("done_and_busy", 1, 0);
  end

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("done_timeout", done, 1);
  endtask

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, output int lat);
    start = 1'b1; a = ta; b = tb; cin = tc;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    wait_done(lat);
  endtask

  int lat;
  int acc0;
  int bound;

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(8'h5A, 8'h3C, 1'b0, lat);
    check("basic_lat", lat, W);
    check("basic_sum", sum, 8'h96);
    check("basic_cout", cout, 0);
    check("basic_busy", busy, 0);
    check("model_basic", res, 9'h096);
    @(negedge clk);

    do_op(8'hFF, 8'h01, 1'b0, lat);
    check("carry1_sum", sum, 8'h00);
    check("carry1_cout", cout, 1);
    @(negedge clk);
    do_op(8'hFF, 8'hFF, 1'b1, lat);
    check("carry2_sum", sum, 8'hFF);
    check("carry2_cout", cout, 1);
    check("model_carry2", res, 9'h1FF);
    @(negedge clk);

    start = 1'b1; a = 8'h5A; b = 8'h3C; cin = 1'b0;
    repeat (4) @(negedge clk);
    a = 8'h00; b = 8'h00;
    wait_done(lat);
    check("ign_first_sum", sum, 8'h96);
    check("ign_first_cout", cout, 0);
    @(negedge clk);
    start = 1'b0;
    check("ign_second_busy", busy, 1);
    check("ign_hold_sum", sum, 8'h96);
    wait_done(lat);
    check("ign_second_lat", lat, W);
    check("ign_second_sum", sum, 8'h00);
    check("ign_second_cout", cout, 0);
    @(negedge clk);

    do_op(8'h5A, 8'h3C, 1'b0, lat);
    start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", busy, 1);
    check("b2b_hold_sum", sum, 8'h96);
    wait_done(lat);
    check("b2b_gap", lat + 1, W + 1);
    check("b2b_sum", sum, 8'h30);
    @(negedge clk);

    start = 1'b1; a = 8'h5A; b = 8'h3C; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_sum", sum, 0);
    check("arst_cout", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(8'h01, 8'h01, 1'b0, lat);
    check("post_rst_lat", lat, W);
    check("post_rst_sum", sum, 8'h02);
    check("post_rst_cout", cout, 0);
    @(negedge clk);

    acc0  = accepted;
    bound = 0;
    while ((accepted - acc0) < 500 && bound < 20000) begin
      start = ($urandom_range(0, 3) == 0);
      a     = W'($urandom);
      b     = W'($urandom);
      cin   = 1'($urandom_range(0, 1));
      @(negedge clk);
      bound++;
    end
    check("random_ops_done", (accepted - acc0) >= 500, 1);
    start = 1'b0;
    repeat (W + 4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller. Sequences a single `full_adder` instance over WIDTH clock cycles to add two WIDTH-bit operands plus a carry-in.
- Provides a start/busy/done handshake and holds the registered result.
- Used where area matters more than latency. One 1-bit datapath is shared over time instead of building a WIDTH-bit ripple adder.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..64

Ports:
clk      input   1      clock; all state updates on rising edge
rst_n    input   1      asynchronous active-low reset
start    input   1      request: begin an addition; sampled on rising clk
a        input   WIDTH  operand A; captured on accepted start
b        input   WIDTH  operand B; captured on accepted start
cin      input   1      carry-in; captured on accepted start
busy     output  1      high while an addition is in progress
done     output  1      one-cycle pulse; sum/cout valid from this cycle on
sum      output  WIDTH  result of last completed addition (registered)
cout     output  1      carry-out of last completed addition (registered)

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rst_n). Asserting rst_n low forces state=IDLE, busy=0, done=0, sum=0, cout=0, and clears all internal regs immediately, with no clock needed.
- Datapath:
  - Exactly one `full_adder` instance computes each bit. No other adder logic is permitted.
  - Internal regs: a_sh, b_sh, r_sh (WIDTH each), carry (1), cnt (clog2(WIDTH+1) bits).
- States: IDLE, RUN, DONE.
- IDLE, or DONE, with start=1 (accepted start):
  - a_sh<=a, b_sh<=b, carry<=cin, cnt<=0.
  - Next state RUN.
- RUN, each edge:
  - Adder inputs: a_sh[0], b_sh[0], carry.
  - r_sh <= {fa_sum, r_sh[WIDTH-1:1]}; a_sh, b_sh shift right by 1; carry<=fa_cout; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1, the last bit is processed: sum<={fa_sum, r_sh[WIDTH-1:1]}, cout<=fa_cout, done<=1, next state DONE.
- DONE: done=1 for exactly this one cycle.
  - If start=1, the start is accepted as from IDLE (back-to-back).
  - Otherwise next state IDLE, and done returns to 0.
- busy = (state==RUN). Registered state decode, no combinational path from start.
- start while RUN is ignored; operands and result are unaffected.
- Latency: start sampled at edge E0, then done=1 and a valid sum/cout after edge E0+WIDTH. Throughput is one addition per WIDTH+1 cycles back-to-back (RUN WIDTH cycles plus DONE 1 cycle).
- sum/cout hold the previous result throughout RUN and only change on the completion edge. a/b/cin may change freely after an accepted start.
- Arithmetic: {cout,sum} = a + b + cin, exact and unsigned, with no truncation beyond WIDTH+1 bits.
- WIDTH=1: RUN lasts one cycle; done follows the edge after the start edge.
- Reset mid-RUN aborts the operation with no done pulse. The first start after reset release is accepted normally.

Test Plan (WIDTH=8):
- Basic add: a=0x5A, b=0x3C, cin=0, start pulse at E0 -> busy=1 for 8 cycles; done pulse after E0+8; sum=0x96, cout=0; busy=0 on done cycle.
- Carry chain: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Ignored start: start held high across the whole RUN with a/b changed to 0x00 mid-run -> first result unaffected (0x5A+0x3C=0x96). Because start remains high on the done cycle, a second operation begins immediately: done cycle followed by busy=1 for 8 cycles, then the second done pulse (sum=0x00, cout=0).
- Back-to-back: start asserted in the done cycle with a=0x10, b=0x20 -> busy next cycle, second done 9 cycles after the first, sum=0x30. Previous sum 0x96 held until then.
- Reset mid-op: rst_n=0 asynchronously at RUN cycle 4 -> busy/done/sum/cout=0 immediately, no done pulse. After release, a=0x01, b=0x01 gives sum=0x02, cout=0.
- Randomised check vs reference model: 500 random a/b/cin with random start gaps -> {cout,sum}==a+b+cin on every done; done is never high while busy.
